// File: rtl/fft_pkg.sv
// Shared FFT definitions: default sizes, the unloader state encoding, and the
// address bit-reversal used by both the input loader and the output streamer.
package fft_pkg;

  localparam int N_PTS   = 64;
  localparam int AW      = $clog2(N_PTS);
  localparam int DW      = 64;
  localparam int REV_MAX = 16;

  typedef enum logic [1:0] {IDLE, PRIME, STREAM, DRAIN} state_t;

  // Reverses the low w bits of a; bits at and above w come back as zero.
  function automatic logic [REV_MAX-1:0] bitrev(input logic [REV_MAX-1:0] a, input int w);
    logic [REV_MAX-1:0] r;
    logic [REV_MAX-1:0] t;
    r = '0;
    t = a;
    for (int i = 0; i < REV_MAX; i++) begin
      if (i < w) begin
        r = {r[REV_MAX-2:0], t[0]};
        t = t >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_out_streamer.sv
// Unloads the FFT result RAM in natural order, two samples per cycle, framed
// by DONE for exactly N/2 cycles; Q trails DONE by one cycle.
module fft_out_streamer
  import fft_pkg::*;
#(
  parameter int N      = N_PTS,
  parameter int DW     = fft_pkg::DW,
  parameter bit BITREV = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 GO,
  output logic                 BUSY,
  output logic                 RD_EN,
  output logic [$clog2(N)-1:0] RD_ADDR0,
  output logic [$clog2(N)-1:0] RD_ADDR1,
  input  logic [DW-1:0]        RD_DATA0,
  input  logic [DW-1:0]        RD_DATA1,
  output logic                 DONE,
  output logic [DW-1:0]        Q0,
  output logic [DW-1:0]        Q1,
  output logic [1:0]           fsm_state
);

  localparam int ADDR_W = $clog2(N);
  localparam int CNT_W  = ADDR_W - 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N / 2 - 1);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [CNT_W-1:0]   pair_sel;
  logic               issue;
  logic               busy_n, rd_en_n, done_n;
  logic [ADDR_W-1:0]  addr0_n, addr1_n;
  logic [DW-1:0]      q0_n, q1_n;

  function automatic logic [ADDR_W-1:0] map_addr(input logic [ADDR_W-1:0] lin);
    if (BITREV) return ADDR_W'(bitrev(REV_MAX'(lin), ADDR_W));
    return lin;
  endfunction

  assign fsm_state = state;

  // Every output is registered, so each transition loads the values the next cycle must show.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    busy_n   = BUSY;
    rd_en_n  = 1'b0;
    done_n   = 1'b0;
    issue    = 1'b0;
    pair_sel = '0;
    q0_n     = Q0;
    q1_n     = Q1;
    case (state)
      IDLE: begin
        if (GO) begin
          state_n = PRIME;
          busy_n  = 1'b1;
          issue   = 1'b1;
          cnt_n   = '0;
        end
      end
      PRIME: begin
        state_n  = STREAM;
        done_n   = 1'b1;
        issue    = 1'b1;
        pair_sel = CNT_W'(1);
        cnt_n    = '0;
      end
      STREAM: begin
        q0_n = RD_DATA0;
        q1_n = RD_DATA1;
        if (cnt == LAST) begin
          state_n = DRAIN;
        end else begin
          cnt_n  = cnt + 1'b1;
          done_n = 1'b1;
          // The final STREAM cycle only consumes data, so it issues no read.
          if (cnt_n != LAST) begin
            issue    = 1'b1;
            pair_sel = cnt + CNT_W'(2);
          end
        end
      end
      DRAIN: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        q0_n    = '0;
        q1_n    = '0;
      end
      default: state_n = IDLE;
    endcase
    rd_en_n = issue;
    addr0_n = issue ? map_addr({pair_sel, 1'b0}) : RD_ADDR0;
    addr1_n = issue ? map_addr({pair_sel, 1'b1}) : RD_ADDR1;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state    <= IDLE;
      cnt      <= '0;
      BUSY     <= 1'b0;
      RD_EN    <= 1'b0;
      DONE     <= 1'b0;
      RD_ADDR0 <= '0;
      RD_ADDR1 <= '0;
      Q0       <= '0;
      Q1       <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      BUSY     <= busy_n;
      RD_EN    <= rd_en_n;
      DONE     <= done_n;
      RD_ADDR0 <= addr0_n;
      RD_ADDR1 <= addr1_n;
      Q0       <= q0_n;
      Q1       <= q1_n;
    end
  end

endmodule

// File: tb/tb_fft_out_streamer.sv
// Bench for fft_out_streamer: three instances (N=64 bit-reversed, N=64 natural,
// N=8 bit-reversed) share GO/RSTn; each has its own RAM, run-timeline model and host-capture monitor.
module tb_fft_out_streamer;

  logic clk;
  logic rstn;
  logic go;

  int n_vec = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d t=%0t: got %h expected %h", name, inst, $time, act, exp);
    end
  endtask

  // Natural index -> RAM address: the RAM holds X[k] at the bit-reversed address of k.
  function automatic int tb_map(input int x, input int bits, input bit br);
    int r;
    int v;
    if (!br) return x;
    r = 0;
    v = x;
    for (int b = 0; b < bits; b++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NN  = (g == 2) ? 8 : 64;
    localparam bit BR  = (g != 1);
    localparam int AWN = $clog2(NN);
    localparam int H   = NN / 2;

    logic            busy, rd_en, done;
    logic [AWN-1:0]  addr0, addr1;
    logic [63:0]     rd0, rd1, q0, q1;
    logic [1:0]      st;
    logic [63:0]     mem [NN];
    logic [63:0]     exp_q[$];
    int              ph = -1;
    int              runs = 0;
    bit              prev_done = 1'b0;
    int              cap = 0;

    fft_out_streamer #(.N(NN), .DW(64), .BITREV(BR)) u_dut (
      .CLK(clk), .RSTn(rstn), .GO(go), .BUSY(busy), .RD_EN(rd_en),
      .RD_ADDR0(addr0), .RD_ADDR1(addr1), .RD_DATA0(rd0), .RD_DATA1(rd1),
      .DONE(done), .Q0(q0), .Q1(q1), .fsm_state(st)
    );

    // Result RAM, one cycle read latency on both ports.
    always @(posedge clk) begin
      if (rd_en) begin
        rd0 <= mem[addr0];
        rd1 <= mem[addr1];
      end
    end

    // Run timeline: ph is cycles since the accepted GO (c0); -1 means idle.
    always @(negedge clk) begin
      bit e_busy, e_done, e_rd, q_live;
      e_busy = rstn && ph >= 1 && ph <= H + 2;
      e_done = rstn && ph >= 2 && ph <= H + 1;
      e_rd   = rstn && ph >= 1 && ph <= H;
      q_live = rstn && ph >= 3 && ph <= H + 2;
      chk("busy", g, 64'(busy), 64'(e_busy));
      chk("done", g, 64'(done), 64'(e_done));
      chk("rd_en", g, 64'(rd_en), 64'(e_rd));
      chk("idle_state", g, 64'(st == fft_pkg::IDLE), 64'(!e_busy));
      if (!q_live) begin
        chk("q0_zero", g, q0, 64'd0);
        chk("q1_zero", g, q1, 64'd0);
      end
      if (e_rd) begin
        chk("addr0", g, 64'(addr0), 64'(tb_map(2 * (ph - 1), AWN, BR)));
        chk("addr1", g, 64'(addr1), 64'(tb_map(2 * (ph - 1) + 1, AWN, BR)));
      end
      if (!rstn) begin
        ph = -1;
        exp_q.delete();
      end else if (ph == -1) begin
        if (go) begin
          ph = 1;
          for (int a = 0; a < NN; a++)
            mem[a] = (runs == 0) ? {32'(a), ~32'(a)} : {$urandom, $urandom};
          runs++;
          for (int j = 0; j < H; j++) begin
            exp_q.push_back(mem[tb_map(2 * j, AWN, BR)]);
            exp_q.push_back(mem[tb_map(2 * j + 1, AWN, BR)]);
          end
        end
      end else begin
        ph++;
        if (ph == H + 3) ph = -1;
      end
    end

    // Host capture: after seeing DONE, take Q on each following cycle.
    always @(negedge clk) begin
      if (!rstn) begin
        prev_done = 1'b0;
        cap = 0;
      end else begin
        if (prev_done) begin
          if (exp_q.size() < 2) begin
            n_vec++;
            n_bad++;
            $display("FAIL capture dut%0d t=%0t: got pair %h/%h expected none", g, $time, q0, q1);
          end else begin
            chk("q0", g, q0, exp_q.pop_front());
            chk("q1", g, q1, exp_q.pop_front());
          end
          cap++;
          if (!done) begin
            chk("pair_count", g, 64'(cap), 64'(H));
            cap = 0;
          end
        end
        prev_done = done;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    go   = 1'b0;
    tick(3);
    rstn = 1'b1;
    tick(1);
    // Single run with the fixed address pattern, then one with random data.
    go = 1'b1; tick(1); go = 1'b0; tick(40);
    go = 1'b1; tick(1); go = 1'b0; tick(40);
    // GO held high: back-to-back restarts, extra GO ignored while busy.
    go = 1'b1; tick(110); go = 1'b0; tick(40);
    // Random GO pulses.
    repeat (300) begin
      go = ($urandom_range(0, 3) == 0);
      tick(1);
    end
    go = 1'b0;
    tick(40);
    // Reset in c12 of a run, then a clean run.
    go = 1'b1; tick(1); go = 1'b0; tick(11);
    rstn = 1'b0; tick(2); rstn = 1'b1;
    go = 1'b1; tick(1); go = 1'b0; tick(40);
    chk("leftover0", 0, 64'(g_dut[0].exp_q.size()), 64'd0);
    chk("leftover1", 1, 64'(g_dut[1].exp_q.size()), 64'd0);
    chk("leftover2", 2, 64'(g_dut[2].exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
